lsu_dmem: RTL and testbench

Parametrised load/store unit with its own byte-addressed data memory, replacing the word-only MEM-stage memory access in the RV32I pipeline. It supports LB/LH/LW/LBU/LHU/SB/SH/SW, including sub-word masking, sign/zero extension and configurable read latency. Access faults are reported through a valid/ready request/response handshake. The MEM stage issues one request at a time and stalls on `req_ready`/`rsp_valid`.

---
 rtl/lsu_pkg.sv | 26 ++
 rtl/lsu_extend.sv | 19 +
 rtl/lsu_dmem.sv | 144 ++++++++++++++
 tb/tb_lsu_dmem.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states and the
// access-size decode.
package lsu_pkg;

    localparam logic [2:0] F3Byte  = 3'd0;
    localparam logic [2:0] F3Half  = 3'd1;
    localparam logic [2:0] F3Word  = 3'd2;
    localparam logic [2:0] F3ByteU = 3'd4;
    localparam logic [2:0] F3HalfU = 3'd5;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } lsu_state_e;

    // Access size in bytes; illegal codes decode as a word and fault elsewhere.
    function automatic logic [2:0] lsu_size(input logic [2:0] funct3);
        case (funct3)
            F3Byte, F3ByteU: return 3'd1;
            F3Half, F3HalfU: return 3'd2;
            default:         return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/lsu_extend.sv
// Load-data formatter: takes four raw little-endian bytes and produces the
// sign- or zero-extended 8/16/32-bit result.
module lsu_extend (
    input  logic [31:0] raw,
    input  logic [2:0]  size,
    input  logic        sign_ext,
    output logic [31:0] result
);

    always_comb begin
        result = raw;
        case (size)
            3'd1:    result = {{24{sign_ext & raw[7]}}, raw[7:0]};
            3'd2:    result = {{16{sign_ext & raw[15]}}, raw[15:0]};
            default: result = raw;
        endcase
    end

endmodule

// File: rtl/lsu_dmem.sv
// Load/store unit with a private byte-addressed data memory and valid/ready
// handshakes. Define LSU_MISALIGN_EN to let misaligned H/W accesses complete.
module lsu_dmem
    import lsu_pkg::*;
#(
    parameter int unsigned DMEM_SIZE = 4096,
    parameter int unsigned LATENCY   = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW     = $clog2(DMEM_SIZE);
    localparam logic [1:0]  LatM1  = 2'(LATENCY - 1);

    logic [7:0] mem [DMEM_SIZE];

    lsu_state_e  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic        accept;
    logic [2:0]  size;
    logic        illegal;
    logic [32:0] end_addr;
    logic        out_of_range;
    logic        misaligned;
    logic        access_err;
    logic [31:0] raw;
    logic [31:0] ext_data;

    assign accept = req_valid && (state_q == StIdle);
    assign size   = lsu_size(req_funct3);

    assign illegal = req_write ? (req_funct3 > F3Word)
                               : (req_funct3 == 3'd3 || req_funct3 == 3'd6 ||
                                  req_funct3 == 3'd7);

    // 33-bit sum so an access near 4 GiB cannot wrap back into range.
    assign end_addr     = {1'b0, req_addr} + 33'(size) - 33'd1;
    assign out_of_range = end_addr >= 33'(DMEM_SIZE);

`ifdef LSU_MISALIGN_EN
    assign misaligned = 1'b0;
`else
    assign misaligned = ((size == 3'd2) && req_addr[0]) ||
                        ((size == 3'd4) && (req_addr[1:0] != 2'b00));
`endif

    assign access_err = illegal || out_of_range || misaligned;

    // Bytes past the top wrap here, but such accesses are already faulted.
    for (genvar i = 0; i < 4; i++) begin : g_raw
        assign raw[8*i +: 8] = mem[req_addr[AW-1:0] + AW'(i)];
    end

    lsu_extend u_extend (
        .raw      (raw),
        .size     (size),
        .sign_ext (~req_funct3[2]),
        .result   (ext_data)
    );

    always_ff @(posedge clock) begin
        if (accept && req_write && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (3'(i) < size) begin
                    mem[req_addr[AW-1:0] + AW'(i)] <= req_wdata[8*i +: 8];
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (access_err || req_write) begin
                        rdata_d = 32'd0;
                        err_d   = access_err;
                        state_d = StResp;
                    end else begin
                        rdata_d = ext_data;
                        err_d   = 1'b0;
                        if (LATENCY > 1) begin
                            cnt_d   = LatM1;
                            state_d = StWait;
                        end else begin
                            state_d = StResp;
                        end
                    end
                end
            end
            StWait: begin
                if (cnt_q <= 2'd1) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 2'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == StIdle);
    assign rsp_valid = (state_q == StResp);
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid & err_q;

endmodule

// File: tb/tb_lsu_dmem.sv
// Self-checking bench for lsu_dmem: two instances (LATENCY 1 and 3) checked
// against a byte-array reference model, directed and randomized accesses.
module tb_lsu_dmem;

    localparam int DMEM = 4096;

    logic        clock = 1'b0;
    logic        reset       [2];
    logic        req_valid   [2];
    logic        req_ready   [2];
    logic        req_write   [2];
    logic [2:0]  req_funct3  [2];
    logic [31:0] req_addr    [2];
    logic [31:0] req_wdata   [2];
    logic        rsp_valid   [2];
    logic        rsp_ready   [2];
    logic [31:0] rsp_rdata   [2];
    logic        rsp_err     [2];

    bit [7:0] mdl [2][DMEM];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    lsu_dmem #(.DMEM_SIZE(DMEM), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_funct3(req_funct3[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
        .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    lsu_dmem #(.DMEM_SIZE(DMEM), .LATENCY(3)) u_dut_l3 (
        .clock(clock), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_funct3(req_funct3[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
        .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Reference: decode size/legality, then read or write the byte array.
    function automatic void model_op(input int d, input bit wr, input bit [2:0] f3,
                                     input bit [31:0] addr, input bit [31:0] wdata,
                                     output bit err, output bit [31:0] rdata);
        int sz;
        bit legal;
        longint v;
        legal = 1'b1;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2:       sz = 4;
            default: begin sz = 4; legal = 1'b0; end
        endcase
        if (wr && f3 > 3'd2) legal = 1'b0;
        err = !legal || (longint'(addr) + longint'(sz) > longint'(DMEM));
`ifndef LSU_MISALIGN_EN
        if (addr % sz != 0) err = 1'b1;
`endif
        rdata = 32'd0;
        if (err) return;
        if (wr) begin
            for (int i = 0; i < sz; i++) mdl[d][addr + i] = 8'((wdata >> (8 * i)) & 32'hFF);
        end else begin
            v = 0;
            for (int i = 0; i < sz; i++) v += longint'(mdl[d][addr + i]) << (8 * i);
            if (f3 < 3'd4 && v >= (longint'(1) << (8 * sz - 1))) v -= longint'(1) << (8 * sz);
            rdata = v[31:0];
        end
    endfunction

    task automatic do_req(input int d, input bit wr, input bit [2:0] f3, input bit [31:0] addr,
                          input bit [31:0] wdata, output logic [31:0] rd, output logic er,
                          output int lat);
        int waited;
        rd = 'x; er = 'x; lat = -1;
        @(negedge clock);
        waited = 0;
        while (!req_ready[d] && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        if (!req_ready[d]) begin
            n_cmp++; n_fail++;
            $display("FAIL accept_timeout dut%0d: req_ready got 0, required 1", d);
            return;
        end
        req_valid[d] = 1'b1; req_write[d] = wr; req_funct3[d] = f3;
        req_addr[d] = addr; req_wdata[d] = wdata; rsp_ready[d] = 1'b0;
        @(posedge clock);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clock);
            req_valid[d] = 1'b0;
            if (rsp_valid[d]) begin
                lat = c; rd = rsp_rdata[d]; er = rsp_err[d];
                break;
            end
        end
        if (lat < 0) begin
            n_cmp++; n_fail++;
            $display("FAIL rsp_timeout dut%0d: rsp_valid got 0, required 1", d);
            return;
        end
        rsp_ready[d] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready[d] = 1'b0;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 2; d++) begin
            n_cmp++; if (req_ready[d] !== 1'b1) begin n_fail++;
                $display("FAIL reset_req_ready dut%0d: got %b, required 1", d, req_ready[d]); end
            n_cmp++; if (rsp_valid[d] !== 1'b0) begin n_fail++;
                $display("FAIL reset_rsp_valid dut%0d: got %b, required 0", d, rsp_valid[d]); end
            n_cmp++; if (rsp_rdata[d] !== 32'd0) begin n_fail++;
                $display("FAIL reset_rsp_rdata dut%0d: got %h, required 0", d, rsp_rdata[d]); end
            n_cmp++; if (rsp_err[d] !== 1'b0) begin n_fail++;
                $display("FAIL reset_rsp_err dut%0d: got %b, required 0", d, rsp_err[d]); end
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr;
        for (int d = 0; d < 2; d++) begin
            do_req(d, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, rd, er, lat);
            model_op(d, 1'b1, 3'd2, 32'h100, 32'hDEADBEEF, xe, xr);
            n_cmp++; if (er !== 1'b0 || lat != 1) begin n_fail++;
                $display("FAIL sw_rsp dut%0d: err=%b lat=%0d, required err=0 lat=1", d, er, lat); end
            do_req(d, 1'b1, 3'd2, 32'h104, 32'h0, rd, er, lat);
            model_op(d, 1'b1, 3'd2, 32'h104, 32'h0, xe, xr);
            do_req(d, 1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
            n_cmp++; if (rd !== 32'hDEADBEEF) begin n_fail++;
                $display("FAIL lw_data dut%0d: got %h, required deadbeef", d, rd); end
            n_cmp++; if (er !== 1'b0) begin n_fail++;
                $display("FAIL lw_err dut%0d: got %b, required 0", d, er); end
            n_cmp++; if (lat != lat_of(d)) begin n_fail++;
                $display("FAIL lw_latency dut%0d: got %0d, required %0d", d, lat, lat_of(d)); end
        end
    endtask

    task automatic test_subword();
        bit [2:0]  f3s [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        bit [31:0] ads [4] = '{32'h103, 32'h103, 32'h102, 32'h102};
        bit [31:0] exp [4] = '{32'hFFFFFFDE, 32'h000000DE, 32'hFFFFDEAD, 32'h0000DEAD};
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr;
        for (int k = 0; k < 4; k++) begin
            do_req(0, 1'b0, f3s[k], ads[k], 32'h0, rd, er, lat);
            n_cmp++; if (rd !== exp[k] || er !== 1'b0) begin n_fail++;
                $display("FAIL subword_load%0d: got %h err=%b, required %h err=0",
                         k, rd, er, exp[k]); end
        end
        do_req(0, 1'b1, 3'd0, 32'h101, 32'h12345655, rd, er, lat);
        model_op(0, 1'b1, 3'd0, 32'h101, 32'h12345655, xe, xr);
        do_req(0, 1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
        n_cmp++; if (rd !== 32'hDEAD55EF) begin n_fail++;
            $display("FAIL sb_merge: got %h, required dead55ef", rd); end
    endtask

    task automatic test_misalign();
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr;
        do_req(0, 1'b0, 3'd2, 32'h101, 32'h0, rd, er, lat);
`ifdef LSU_MISALIGN_EN
        n_cmp++; if (rd !== 32'h00DEAD55 || er !== 1'b0) begin n_fail++;
            $display("FAIL misalign_lw: got %h err=%b, required 00dead55 err=0", rd, er); end
`else
        n_cmp++; if (rd !== 32'h0 || er !== 1'b1) begin n_fail++;
            $display("FAIL misalign_lw: got %h err=%b, required 0 err=1", rd, er); end
`endif
        do_req(0, 1'b1, 3'd2, 32'h102, 32'hCAFEF00D, rd, er, lat);
        model_op(0, 1'b1, 3'd2, 32'h102, 32'hCAFEF00D, xe, xr);
        n_cmp++; if (er !== xe) begin n_fail++;
            $display("FAIL misalign_sw_err: got %b, required %b", er, xe); end
        do_req(0, 1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
        model_op(0, 1'b0, 3'd2, 32'h100, 32'h0, xe, xr);
        n_cmp++; if (rd !== xr) begin n_fail++;
            $display("FAIL misalign_sw_effect: got %h, required %h", rd, xr); end
    endtask

    task automatic test_boundary();
        bit        wrs [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        bit [2:0]  f3s [6] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd4, 3'd2};
        bit [31:0] ads [6] = '{DMEM - 2, 32'h100, 32'h100, DMEM - 1, DMEM - 1, 32'h100};
        bit [31:0] wds [6] = '{32'h0, 32'h0, 32'h77777777, 32'hA5, 32'h0, 32'h0};
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr;
        for (int k = 0; k < 6; k++) begin
            do_req(0, wrs[k], f3s[k], ads[k], wds[k], rd, er, lat);
            model_op(0, wrs[k], f3s[k], ads[k], wds[k], xe, xr);
            n_cmp++; if (rd !== xr || er !== xe || lat != 1) begin n_fail++;
                $display("FAIL boundary%0d: got %h err=%b lat=%0d, required %h err=%b lat=1",
                         k, rd, er, lat, xr, xe); end
        end
        do_req(0, 1'b0, 3'd2, DMEM - 2, 32'h0, rd, er, lat);
        n_cmp++; if (er !== 1'b1) begin n_fail++;
            $display("FAIL lw_top_err: got %b, required 1", er); end
    endtask

    task automatic test_backpressure();
        logic [31:0] exp_rd; bit xe; bit [31:0] xr; bit seen;
        model_op(1, 1'b0, 3'd2, 32'h100, 32'h0, xe, xr);
        exp_rd = xr;
        @(negedge clock);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h100; rsp_ready[1] = 1'b0;
        @(posedge clock);
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            req_valid[1] = 1'b0;
            seen = rsp_valid[1];
        end
        n_cmp++; if (!seen) begin n_fail++;
            $display("FAIL bp_rsp_timeout: rsp_valid got 0, required 1"); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (rsp_valid[1] !== 1'b1 || rsp_rdata[1] !== exp_rd ||
                         rsp_err[1] !== 1'b0 || req_ready[1] !== 1'b0) begin n_fail++;
                $display("FAIL bp_hold%0d: valid=%b rdata=%h err=%b ready=%b, required 1 %h 0 0",
                         k, rsp_valid[1], rsp_rdata[1], rsp_err[1], req_ready[1], exp_rd); end
        end
        rsp_ready[1] = 1'b1;
        @(posedge clock);
        @(negedge clock);
        rsp_ready[1] = 1'b0;
        n_cmp++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin n_fail++;
            $display("FAIL bp_release: ready=%b valid=%b, required 1 0",
                     req_ready[1], rsp_valid[1]); end
    endtask

    task automatic test_reset_in_wait();
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr; bit rose;
        @(negedge clock);
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_funct3[1] = 3'd2;
        req_addr[1] = 32'h100; rsp_ready[1] = 1'b0;
        @(posedge clock);
        @(negedge clock);
        req_valid[1] = 1'b0;
        reset[1] = 1'b0;
        #1;
        n_cmp++; if (req_ready[1] !== 1'b1 || rsp_valid[1] !== 1'b0) begin n_fail++;
            $display("FAIL rst_wait_immediate: ready=%b valid=%b, required 1 0",
                     req_ready[1], rsp_valid[1]); end
        rose = 1'b0;
        repeat (2) begin @(negedge clock); rose |= rsp_valid[1]; end
        reset[1] = 1'b1;
        repeat (6) begin @(negedge clock); rose |= rsp_valid[1]; end
        n_cmp++; if (rose) begin n_fail++;
            $display("FAIL rst_wait_no_rsp: rsp_valid got 1, required 0"); end
        do_req(1, 1'b0, 3'd2, 32'h100, 32'h0, rd, er, lat);
        model_op(1, 1'b0, 3'd2, 32'h100, 32'h0, xe, xr);
        n_cmp++; if (rd !== xr || er !== 1'b0) begin n_fail++;
            $display("FAIL rst_wait_persist: got %h err=%b, required %h err=0", rd, er, xr); end
    endtask

    task automatic test_random();
        logic [31:0] rd; logic er; int lat; bit xe; bit [31:0] xr;
        bit wr; bit [2:0] f3; bit [31:0] ad, wd; int exp_lat;
        for (int d = 0; d < 2; d++) begin
            for (int a = 32'h200; a < 32'h248; a += 4) begin
                wd = $urandom;
                do_req(d, 1'b1, 3'd2, a, wd, rd, er, lat);
                model_op(d, 1'b1, 3'd2, a, wd, xe, xr);
            end
            for (int k = 0; k < 40; k++) begin
                wr = 1'($urandom_range(0, 1));
                f3 = 3'($urandom_range(0, 7));
                ad = 32'h200 + $urandom_range(0, 63);
                wd = $urandom;
                do_req(d, wr, f3, ad, wd, rd, er, lat);
                model_op(d, wr, f3, ad, wd, xe, xr);
                exp_lat = (xe || wr) ? 1 : lat_of(d);
                n_cmp++; if (rd !== xr || er !== xe || lat != exp_lat) begin n_fail++;
                    $display("FAIL random dut%0d #%0d wr=%b f3=%0d addr=%h: got %h err=%b lat=%0d, required %h err=%b lat=%0d",
                             d, k, wr, f3, ad, rd, er, lat, xr, xe, exp_lat); end
            end
        end
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset[d] = 1'b0; req_valid[d] = 1'b0; req_write[d] = 1'b0; req_funct3[d] = 3'd0;
            req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
        end
        repeat (3) @(negedge clock);
        reset[0] = 1'b1;
        reset[1] = 1'b1;
        @(negedge clock);
        test_reset();
        test_word();
        test_subword();
        test_misalign();
        test_boundary();
        test_backpressure();
        test_reset_in_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
